peripheral_mpi_biu_ahb3: RTL and testbench

AHB3-Lite slave bus interface for the MPI message buffers, generalised to XLEN-wide data and N independent buffer channels. It implements full AHB address/data phase pipelining, wait-state insertion and the two-cycle ERROR response. Each accepted transfer is converted into a single handshaked access on a one-hot generic bus toward the per-channel `peripheral_mpi_buffer` instances.

---
 rtl/peripheral_mpi_biu_ahb3.sv | 190 +++++++++++++++++++
 tb/tb_peripheral_mpi_biu_ahb3.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_mpi_biu_ahb3.sv
// peripheral_mpi_biu_ahb3
// AHB3-Lite slave front end for the MPI message buffers. Each accepted AHB
// transfer becomes one handshaked access on a one-hot generic bus toward
// N buffer channels. Illegal transfers (wrong size, channel out of range)
// and channel errors return the two-cycle AHB ERROR response.
// Optional feature macro: PERIPHERAL_MPI_BIU_TIMEOUT_EN (aborts an ACCESS
// that sees no ack/err within TIMEOUT cycles).
module peripheral_mpi_biu_ahb3 #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int N       = 1,
  parameter int CH_LSB  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              biu_hsel_i,
  input  logic [PLEN-1:0]   biu_haddr_i,
  input  logic [XLEN-1:0]   biu_hwdata_i,
  input  logic              biu_hwrite_i,
  input  logic [2:0]        biu_hsize_i,
  input  logic [2:0]        biu_hburst_i,
  input  logic [3:0]        biu_hprot_i,
  input  logic [1:0]        biu_htrans_i,
  input  logic              biu_hmastlock_i,
  input  logic              biu_hready_i,
  output logic [XLEN-1:0]   biu_hrdata_o,
  output logic              biu_hreadyout_o,
  output logic              biu_hresp_o,
  output logic [CH_LSB-1:0] bus_addr,
  output logic              bus_we,
  output logic [N-1:0]      bus_en,
  output logic [XLEN-1:0]   bus_data_in,
  input  logic [N*XLEN-1:0] bus_data_out,
  input  logic [N-1:0]      bus_ack,
  input  logic [N-1:0]      bus_err
);

  // Channel index field width; a single channel still keeps a 1-bit register.
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  // Only full-width (XLEN) transfers are supported.
  localparam logic [2:0] HSIZE_W = 3'($clog2(XLEN / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [CHW-1:0]    ch_q, ch_d, ch_req;
  logic [CH_LSB-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [N-1:0]      en_mask;
  logic [XLEN-1:0]   rsel;
  logic              ch_ok, accept, legal, sel_ack, sel_err, tmo;

  // Burst, protection, lock and the address bits above the channel field
  // carry no meaning for this slave.
  logic unused_ahb;
  assign unused_ahb = ^{biu_hburst_i, biu_hprot_i, biu_hmastlock_i,
                        biu_haddr_i, biu_htrans_i[0]};

  // Decode the channel index of the address phase.
  generate
    if (N > 1) begin : g_multi
      assign ch_req = biu_haddr_i[CH_LSB +: CHW];
      assign ch_ok  = (int'(ch_req) < N);
    end else begin : g_single
      assign ch_req = 1'b0;
      assign ch_ok  = 1'b1;
    end
  endgenerate

  assign accept = biu_hsel_i & biu_htrans_i[1] & biu_hready_i;
  assign legal  = (biu_hsize_i == HSIZE_W) & ch_ok;

  // One-hot select of the latched channel and its read-data slice.
  always_comb begin
    en_mask = '0;
    rsel    = '0;
    for (int c = 0; c < N; c++) begin
      if (ch_q == CHW'(c)) begin
        en_mask[c] = 1'b1;
        rsel       = bus_data_out[c*XLEN +: XLEN];
      end
    end
  end

  // Responses from channels other than the active one are ignored.
  assign sel_ack = |(bus_ack & en_mask);
  assign sel_err = |(bus_err & en_mask);

`ifdef PERIPHERAL_MPI_BIU_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 256) ? 8 : 16;
  logic [CW-1:0] cnt_q, cnt_d;

  // Cycles spent in the current ACCESS; held at zero outside ACCESS so each
  // entry starts a fresh count.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_ACCESS) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires in the TIMEOUT-th ACCESS cycle.
  assign tmo = (cnt_d == CW'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state, latched request fields and AHB/bus outputs.
  always_comb begin
    state_d         = state_q;
    ch_d            = ch_q;
    addr_d          = addr_q;
    we_d            = we_q;
    rdata_d         = rdata_q;
    biu_hreadyout_o = 1'b1;
    biu_hresp_o     = 1'b0;
    bus_en          = '0;
    case (state_q)
      S_ACCESS: begin
        biu_hreadyout_o = 1'b0;
        bus_en          = en_mask;
        // An error beats a same-cycle ack; an ack beats the timeout.
        if (sel_err) begin
          state_d = S_ERR1;
        end else if (sel_ack) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = rsel;
        end else if (tmo) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        biu_hreadyout_o = 1'b0;
        biu_hresp_o     = 1'b1;
        state_d         = S_ERR2;
      end
      default: begin
        // IDLE, DONE and ERR2 all complete with HREADY high, so each can
        // take the next address phase directly.
        biu_hresp_o = (state_q == S_ERR2);
        state_d     = S_IDLE;
        if (accept) begin
          if (legal) begin
            state_d = S_ACCESS;
            ch_d    = ch_req;
            addr_d  = biu_haddr_i[CH_LSB-1:0];
            we_d    = biu_hwrite_i;
          end else begin
            state_d = S_ERR1;
          end
        end
      end
    endcase
  end

  assign biu_hrdata_o = rdata_q;
  assign bus_addr     = addr_q;
  assign bus_we       = we_q;
  assign bus_data_in  = biu_hwdata_i;

endmodule

// File: tb/tb_peripheral_mpi_biu_ahb3.sv
// Bench for peripheral_mpi_biu_ahb3 with N=3 channels and TIMEOUT=4.
// Table vectors follow the directed scenarios; a randomized phase checks
// responses and read data against a word-memory reference model.
module tb_peripheral_mpi_biu_ahb3;
  localparam int N  = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsel = 1'b0, hwrite = 1'b0, hmastlock = 1'b0, hready;
  logic [31:0]   haddr = '0, hwdata = '0, hrdata;
  logic [2:0]    hsize = 3'd2, hburst = '0;
  logic [3:0]    hprot = '0;
  logic [1:0]    htrans = '0;
  logic          hreadyout, hresp, bus_we;
  logic [11:0]   bus_addr;
  logic [N-1:0]  bus_en, bus_ack = '0, bus_err = '0;
  logic [31:0]   bus_data_in;
  logic [N*32-1:0] bus_data_out = '0;

  int npass = 0, ntot = 0, cyc = 0;
  logic [31:0] smem [N*1024];   // contents held by the channel slaves
  logic [31:0] rmem [N*1024];   // reference model of the same memory
  logic [31:0] exp_hr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign hready = hreadyout;    // single slave on the bus

  peripheral_mpi_biu_ahb3 #(.PLEN(32), .XLEN(32), .N(N), .CH_LSB(12), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .biu_hsel_i(hsel), .biu_haddr_i(haddr), .biu_hwdata_i(hwdata),
    .biu_hwrite_i(hwrite), .biu_hsize_i(hsize), .biu_hburst_i(hburst),
    .biu_hprot_i(hprot), .biu_htrans_i(htrans), .biu_hmastlock_i(hmastlock),
    .biu_hready_i(hready), .biu_hrdata_o(hrdata), .biu_hreadyout_o(hreadyout),
    .biu_hresp_o(hresp), .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_err(bus_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00;
    repeat (n) begin
      @(negedge clk);
      chk("idle_rdy", hreadyout, 1'b1);
      chk("idle_resp", hresp, 1'b0);
      chk("idle_en", bus_en, '0);
    end
  endtask

  // One transfer, starting at a negedge with the slave ready and ending at
  // the negedge of its last response cycle (DONE or ERR2).
  // em: 0 ack, 1 err, 2 ack+err same cycle, 3 never respond.
  task automatic xfer(input logic wr, input logic [1:0] ch, input logic [11:0] off,
                      input logic [2:0] sz, input logic [31:0] wd, input int dly,
                      input int em, output logic err_seen);
    logic legal, ok;
    logic [N-1:0] oh;
    logic [31:0] r;
    int idx, sidx;
    legal = (sz == 3'd2) && (ch < N);
    ok    = legal && (em == 0);
    oh    = legal ? N'(1 << ch) : '0;
    idx   = int'(ch) * 1024 + int'(off[11:2]);
    r     = $urandom();
    hsel = 1'b1; htrans = 2'b10; haddr = {r[31:14], ch, off}; hwrite = wr; hsize = sz;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom(); hwdata = wd;
    if (legal) begin
      for (int n = 0; n <= dly; n++) begin
        chk("acc_rdy", hreadyout, 1'b0);
        chk("acc_resp", hresp, 1'b0);
        chk("acc_en", bus_en, oh);
        chk("acc_we", bus_we, wr);
        chk("acc_addr", bus_addr, off);
        if (wr) chk("acc_wdata", bus_data_in, wd);
        for (int c = 0; c < N; c++) bus_data_out[c*32 +: 32] = $urandom();
        bus_ack = N'($urandom()) & ~oh;
        bus_err = N'($urandom()) & ~oh;
        if (n == dly && em != 3) begin
          sidx = int'(ch) * 1024 + int'(bus_addr[11:2]);
          if (em != 1) bus_ack[ch] = 1'b1;
          if (em != 0) bus_err[ch] = 1'b1;
          if (!wr) bus_data_out[int'(ch)*32 +: 32] = smem[sidx];
          else if (em == 0) smem[sidx] = bus_data_in;
        end
        @(negedge clk);
        bus_ack = '0; bus_err = '0;
      end
    end
    if (ok) begin
      if (wr) rmem[idx] = wd;
      else exp_hr = rmem[idx];
      chk("done_rdy", hreadyout, 1'b1);
      chk("done_resp", hresp, 1'b0);
      chk("done_en", bus_en, '0);
      chk("done_hrdata", hrdata, exp_hr);
    end else begin
      chk("err1_rdy", hreadyout, 1'b0);
      chk("err1_resp", hresp, 1'b1);
      chk("err1_en", bus_en, '0);
      @(negedge clk);
      chk("err2_rdy", hreadyout, 1'b1);
      chk("err2_resp", hresp, 1'b1);
      chk("err2_en", bus_en, '0);
      chk("err_hrdata_hold", hrdata, exp_hr);
    end
    err_seen = hresp;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [11:0] off;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          dly;
    int          em;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic e;
    int c0, d1, d2, d3;
    tbl[0] = '{1'b1, 2'd0, 12'h004, 3'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 2'd1, 12'h010, 3'd2, 32'h12345678, 1, 0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 2'd1, 12'h010, 3'd2, 32'h0,        2, 0, 1'b0, 32'h12345678};
    tbl[3] = '{1'b0, 2'd0, 12'h004, 3'd0, 32'h0,        0, 0, 1'b1, 32'h12345678};
    tbl[4] = '{1'b1, 2'd3, 12'h000, 3'd2, 32'h55555555, 0, 0, 1'b1, 32'h12345678};
    tbl[5] = '{1'b0, 2'd0, 12'h004, 3'd2, 32'h0,        1, 1, 1'b1, 32'h12345678};
    tbl[6] = '{1'b1, 2'd2, 12'h008, 3'd2, 32'hCAFEF00D, 0, 2, 1'b1, 32'h12345678};
    tbl[7] = '{1'b0, 2'd0, 12'h004, 3'd2, 32'h0,        0, 0, 1'b0, 32'hDEADBEEF};
    for (int i = 0; i < N*1024; i++) begin smem[i] = '0; rmem[i] = '0; end

    // Reset values while reset is held.
    #2;
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_rdy", hreadyout, 1'b1);
    chk("rst_resp", hresp, 1'b0);
    chk("rst_en", bus_en, '0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 12'h0);
    @(negedge clk); rst = 1'b0;
    idle(1);

    // BUSY transfer: zero-wait OKAY, no channel access.
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_1000;
    @(negedge clk);
    chk("busy_rdy", hreadyout, 1'b1);
    chk("busy_resp", hresp, 1'b0);
    chk("busy_en", bus_en, '0);
    idle(1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].wr, tbl[i].ch, tbl[i].off, tbl[i].sz, tbl[i].wd, tbl[i].dly, tbl[i].em, e);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
      chk($sformatf("tbl%0d_hrdata", i), hrdata, tbl[i].exp_rd);
      idle(1);
    end

    // Back-to-back write, read, write: one completion every 2 cycles.
    c0 = cyc;
    xfer(1'b1, 2'd0, 12'h020, 3'd2, 32'hAAAA5555, 0, 0, e); d1 = cyc;
    xfer(1'b0, 2'd0, 12'h020, 3'd2, 32'h0,        0, 0, e); d2 = cyc;
    chk("b2b_hrdata", hrdata, 32'hAAAA5555);
    xfer(1'b1, 2'd1, 12'h024, 3'd2, 32'h0BADCAFE, 0, 0, e); d3 = cyc;
    chk("b2b_cyc1", d1 - c0, 2);
    chk("b2b_cyc2", d2 - c0, 4);
    chk("b2b_cyc3", d3 - c0, 6);
    idle(1);

`ifdef PERIPHERAL_MPI_BIU_TIMEOUT_EN
    // No ack: ERROR begins after TIMEOUT access cycles.
    c0 = cyc;
    xfer(1'b0, 2'd2, 12'h030, 3'd2, 32'h0, TO - 1, 3, e);
    chk("tmo_err", e, 1'b1);
    chk("tmo_cycles", cyc - c0, TO + 2);
    idle(1);
`endif

    // Randomized traffic, with and without idle gaps between transfers.
    for (int i = 0; i < 200; i++) begin
      logic        wr;
      logic [1:0]  ch;
      logic [11:0] off;
      logic [2:0]  sz;
      int          em, k;
      wr  = 1'($urandom_range(0, 1));
      ch  = 2'($urandom_range(0, 3));
      off = {4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 2'b00};
      k   = $urandom_range(0, 9);
      sz  = (k < 8) ? 3'd2 : 3'($urandom_range(0, 7));
      k   = $urandom_range(0, 9);
      em  = (k < 7) ? 0 : (k < 9) ? 1 : 2;
      xfer(wr, ch, off, sz, $urandom(), $urandom_range(0, 3), em, e);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    // Reset mid-ACCESS: outputs return to reset values immediately.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_2010; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    chk("mid_en", bus_en, 3'b100);
    chk("mid_rdy", hreadyout, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", bus_en, '0);
    chk("mid_rst_rdy", hreadyout, 1'b1);
    chk("mid_rst_resp", hresp, 1'b0);
    chk("mid_rst_we", bus_we, 1'b0);
    chk("mid_rst_addr", bus_addr, 12'h0);
    chk("mid_rst_hrdata", hrdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    exp_hr = '0;
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
